// File: rtl/rob_multicommit.sv
// Reorder buffer with count-based occupancy, N writeback ports, up to two
// in-order retirements per cycle, same-cycle writeback bypass on operand
// lookup, and a registered mispredict flush pulse.
module rob_multicommit #(
  parameter int ROB_DEPTH = 16,
  parameter int ID_W      = 4,
  parameter int XLEN      = 32,
  parameter int WB_PORTS  = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     disp_valid,
  input  logic [XLEN-1:0]          disp_pc,
  input  logic [4:0]               disp_rd,
  input  logic                     disp_is_jump,
  input  logic                     disp_is_ls,
  input  logic                     disp_pred_taken,
  output logic [ID_W-1:0]          disp_tag,
  output logic                     rob_full,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*ID_W-1:0] wb_tag,
  input  logic [WB_PORTS*XLEN-1:0] wb_res,
  input  logic [WB_PORTS-1:0]      wb_taken,
  input  logic [WB_PORTS*XLEN-1:0] wb_target,
  input  logic [ID_W-1:0]          q1_tag,
  input  logic [ID_W-1:0]          q2_tag,
  output logic                     q1_ready,
  output logic                     q2_ready,
  output logic [XLEN-1:0]          q1_val,
  output logic [XLEN-1:0]          q2_val,
  output logic                     ls_head_valid,
  output logic [ID_W-1:0]          ls_head_tag,
  output logic [COMMIT_W-1:0]      commit_valid,
  output logic [COMMIT_W*5-1:0]    commit_rd,
  output logic [COMMIT_W*XLEN-1:0] commit_res,
  output logic [COMMIT_W*ID_W-1:0] commit_tag,
  output logic                     flush,
  output logic [XLEN-1:0]          flush_pc,
  output logic                     bp_update_valid,
  output logic [XLEN-1:0]          bp_update_pc,
  output logic                     bp_update_taken
);

  logic [ID_W-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
  logic [ID_W:0]   count_q, count_d;

  logic [ROB_DEPTH-1:0] valid_q, ready_q, is_jump_q, is_ls_q, pred_q, taken_q;
  logic [XLEN-1:0]      pc_q     [ROB_DEPTH];
  logic [XLEN-1:0]      res_q    [ROB_DEPTH];
  logic [XLEN-1:0]      target_q [ROB_DEPTH];
  logic [4:0]           rd_q     [ROB_DEPTH];

  // Commit outputs are kept two slots wide internally and trimmed at the port.
  logic [1:0]        commit_valid_q, commit_valid_d;
  logic [9:0]        commit_rd_q, commit_rd_d;
  logic [2*XLEN-1:0] commit_res_q, commit_res_d;
  logic [2*ID_W-1:0] commit_tag_q, commit_tag_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   flush_pc_q, flush_pc_d;
  logic              bp_valid_q, bp_valid_d;
  logic [XLEN-1:0]   bp_pc_q, bp_pc_d;
  logic              bp_taken_q, bp_taken_d;

  logic            disp_fire, retire0, retire1, jmp_fire;
  logic [ID_W-1:0] jmp_idx;

  assign head_nxt      = head_q + ID_W'(1);
  assign disp_tag      = tail_q;
  assign rob_full      = (count_q == (ID_W+1)'(ROB_DEPTH));
  assign disp_fire     = disp_valid && !rob_full && !flush_q;
  assign ls_head_valid = (count_q != '0) && is_ls_q[head_q];
  assign ls_head_tag   = head_q;

  assign commit_valid    = commit_valid_q[COMMIT_W-1:0];
  assign commit_rd       = commit_rd_q[COMMIT_W*5-1:0];
  assign commit_res      = commit_res_q[COMMIT_W*XLEN-1:0];
  assign commit_tag      = commit_tag_q[COMMIT_W*ID_W-1:0];
  assign flush           = flush_q;
  assign flush_pc        = flush_pc_q;
  assign bp_update_valid = bp_valid_q;
  assign bp_update_pc    = bp_pc_q;
  assign bp_update_taken = bp_taken_q;

  // Operand lookup: registered result, overridden by a matching writeback this cycle (lowest port wins).
  always_comb begin
    q1_ready = ready_q[q1_tag];
    q1_val   = res_q[q1_tag];
    q2_ready = ready_q[q2_tag];
    q2_val   = res_q[q2_tag];
    for (int p = WB_PORTS-1; p >= 0; p--) begin
      if (wb_valid[p] && (wb_tag[p*ID_W +: ID_W] == q1_tag)) begin
        q1_ready = 1'b1;
        q1_val   = wb_res[p*XLEN +: XLEN];
      end
      if (wb_valid[p] && (wb_tag[p*ID_W +: ID_W] == q2_tag)) begin
        q2_ready = 1'b1;
        q2_val   = wb_res[p*XLEN +: XLEN];
      end
    end
  end

  // Retire selection, branch resolution and next pointer/count values.
  always_comb begin
    commit_valid_d = '0;
    commit_rd_d    = '0;
    commit_res_d   = '0;
    commit_tag_d   = '0;
    flush_d        = 1'b0;
    flush_pc_d     = '0;
    bp_valid_d     = 1'b0;
    bp_pc_d        = '0;
    bp_taken_d     = 1'b0;
    jmp_fire       = 1'b0;
    jmp_idx        = head_q;

    retire0 = (count_q != '0) && ready_q[head_q];
    retire1 = (COMMIT_W == 2) && retire0 && (count_q > (ID_W+1)'(1)) &&
              ready_q[head_nxt] && !is_jump_q[head_q] && !is_ls_q[head_q] &&
              !is_ls_q[head_nxt];

    if (retire0) begin
      commit_valid_d[0]        = 1'b1;
      commit_rd_d[4:0]         = rd_q[head_q];
      commit_res_d[XLEN-1:0]   = res_q[head_q];
      commit_tag_d[ID_W-1:0]   = head_q;
      if (is_jump_q[head_q]) begin
        jmp_fire = 1'b1;
        jmp_idx  = head_q;
      end
    end
    if (retire1) begin
      commit_valid_d[1]         = 1'b1;
      commit_rd_d[9:5]          = rd_q[head_nxt];
      commit_res_d[2*XLEN-1:XLEN] = res_q[head_nxt];
      commit_tag_d[2*ID_W-1:ID_W] = head_nxt;
      if (is_jump_q[head_nxt]) begin
        jmp_fire = 1'b1;
        jmp_idx  = head_nxt;
      end
    end

    if (jmp_fire) begin
      bp_valid_d = 1'b1;
      bp_pc_d    = pc_q[jmp_idx];
      bp_taken_d = taken_q[jmp_idx];
      if (taken_q[jmp_idx] != pred_q[jmp_idx]) begin
        flush_d    = 1'b1;
        flush_pc_d = taken_q[jmp_idx] ? target_q[jmp_idx] : pc_q[jmp_idx] + XLEN'(4);
      end
    end

    head_d  = head_q + (retire1 ? ID_W'(2) : (retire0 ? ID_W'(1) : ID_W'(0)));
    tail_d  = tail_q + ID_W'(disp_fire);
    count_d = count_q + (ID_W+1)'(disp_fire)
              - (retire1 ? (ID_W+1)'(2) : (retire0 ? (ID_W+1)'(1) : (ID_W+1)'(0)));
  end

  // State update: reset, stall on rdy low, flush clear, else writeback/retire/dispatch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      ready_q        <= '0;
      is_jump_q      <= '0;
      is_ls_q        <= '0;
      pred_q         <= '0;
      taken_q        <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        pc_q[i]     <= '0;
        res_q[i]    <= '0;
        target_q[i] <= '0;
        rd_q[i]     <= '0;
      end
      commit_valid_q <= '0;
      commit_rd_q    <= '0;
      commit_res_q   <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
      bp_valid_q     <= 1'b0;
      bp_pc_q        <= '0;
      bp_taken_q     <= 1'b0;
    end else if (rdy) begin
      if (flush_q) begin
        head_q         <= '0;
        tail_q         <= '0;
        count_q        <= '0;
        valid_q        <= '0;
        ready_q        <= '0;
        commit_valid_q <= '0;
        commit_rd_q    <= '0;
        commit_res_q   <= '0;
        commit_tag_q   <= '0;
        flush_q        <= 1'b0;
        flush_pc_q     <= '0;
        bp_valid_q     <= 1'b0;
        bp_pc_q        <= '0;
        bp_taken_q     <= 1'b0;
      end else begin
        head_q         <= head_d;
        tail_q         <= tail_d;
        count_q        <= count_d;
        commit_valid_q <= commit_valid_d;
        commit_rd_q    <= commit_rd_d;
        commit_res_q   <= commit_res_d;
        commit_tag_q   <= commit_tag_d;
        flush_q        <= flush_d;
        flush_pc_q     <= flush_pc_d;
        bp_valid_q     <= bp_valid_d;
        bp_pc_q        <= bp_pc_d;
        bp_taken_q     <= bp_taken_d;

        for (int p = WB_PORTS-1; p >= 0; p--) begin
          if (wb_valid[p] && valid_q[wb_tag[p*ID_W +: ID_W]]) begin
            ready_q[wb_tag[p*ID_W +: ID_W]]  <= 1'b1;
            res_q[wb_tag[p*ID_W +: ID_W]]    <= wb_res[p*XLEN +: XLEN];
            taken_q[wb_tag[p*ID_W +: ID_W]]  <= wb_taken[p];
            target_q[wb_tag[p*ID_W +: ID_W]] <= wb_target[p*XLEN +: XLEN];
          end
        end

        if (retire0) begin
          valid_q[head_q] <= 1'b0;
          ready_q[head_q] <= 1'b0;
        end
        if (retire1) begin
          valid_q[head_nxt] <= 1'b0;
          ready_q[head_nxt] <= 1'b0;
        end

        if (disp_fire) begin
          valid_q[tail_q]   <= 1'b1;
          ready_q[tail_q]   <= 1'b0;
          is_jump_q[tail_q] <= disp_is_jump;
          is_ls_q[tail_q]   <= disp_is_ls;
          pred_q[tail_q]    <= disp_pred_taken;
          taken_q[tail_q]   <= 1'b0;
          pc_q[tail_q]      <= disp_pc;
          rd_q[tail_q]      <= disp_rd;
          res_q[tail_q]     <= '0;
          target_q[tail_q]  <= '0;
        end
      end
    end
  end

endmodule
